rom_arbiter: RTL and testbench

Shares the single-port synchronous instruction ROM between two requesters. The instruction-fetch port (ibus) and the data-load port (dbus) both read it, so the core can load constants and jump tables from ROM. The block sits between the fetch/memory stages and the ROM macro. It performs priority arbitration with a starvation guard, range checks addresses, and routes the 1-cycle-latency ROM data back to the owner of each read.

---
 rtl/rom_arb_pkg.sv | 31 +++
 rtl/rom_starve_ctr.sv | 36 +++
 rtl/rom_arbiter.sv | 98 +++++++++
 tb/tb_rom_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the instruction-ROM arbiter.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
// Contents: owner_e (which port owns the ROM read in flight) and
//           is_rom_fault() (address range check against the ROM span).
package rom_arb_pkg;

  // Widest byte address the range-check helper accepts.
  localparam int unsigned ADDR_MAX = 64;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IBUS = 2'd1,
    OWN_DBUS = 2'd2
  } owner_e;

  // An access faults when any byte-address bit above the ROM span is set.
  // addr_width limits the check to the real address bits, so callers may
  // pass a zero-extended address.
  function automatic logic is_rom_fault(input logic [ADDR_MAX-1:0] addr,
                                        input int unsigned       addr_width,
                                        input int unsigned       rom_aw);
    logic f;
    f = 1'b0;
    for (int unsigned i = 0; i < ADDR_MAX; i++) begin
      if ((i >= rom_aw + 2) && (i < addr_width) && addr[i]) f = 1'b1;
    end
    return f;
  endfunction

endpackage

// File: rtl/rom_starve_ctr.sv
// Saturating starvation counter for the ibus side of the ROM arbiter.
// Latency: force_i reflects the count registered at the last clock edge.
// Backpressure: none; counts denied in-range ibus cycles only.
// Ports: clk, rst (async, active-high); ibus_req, ibus_inrange, ibus_gnt in;
//        force_i out (ibus must win this cycle).
module rom_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ibus_req,
  input  logic ibus_inrange,
  input  logic ibus_gnt,
  output logic force_i
);

  // A limit of 0 disables the guard; keep a 1-bit counter so the
  // declaration stays legal.
  localparam int unsigned CW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!ibus_req || ibus_gnt) begin
      starve_cnt <= '0;
    end else if (ibus_inrange && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_i = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates the single-port synchronous instruction ROM between fetch
// (ibus) and data loads (dbus); dbus has priority, with a starvation guard.
// Latency: response exactly 1 cycle after grant. Backpressure: none on the
// response; a denied requester holds req/addr until granted.
// Ports: ibus_* / dbus_* request (req, addr, gnt) and response
//        (rvalid, rdata, fault); rom_rd_en / rom_addr / rom_rd_data to ROM.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned ROM_ADDR_WIDTH = 10,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ibus_req,
  input  logic [WIDTH-1:0]          ibus_addr,
  output logic                      ibus_gnt,
  output logic                      ibus_rvalid,
  output logic [WIDTH-1:0]          ibus_rdata,
  output logic                      ibus_fault,
  input  logic                      dbus_req,
  input  logic [WIDTH-1:0]          dbus_addr,
  output logic                      dbus_gnt,
  output logic                      dbus_rvalid,
  output logic [WIDTH-1:0]          dbus_rdata,
  output logic                      dbus_fault,
  output logic                      rom_rd_en,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]          rom_rd_data
);

  logic [ADDR_MAX-1:0] ibus_addr_ext;
  logic [ADDR_MAX-1:0] dbus_addr_ext;
  logic ibus_flt, dbus_flt;   // requesting, out of range
  logic ibus_ok,  dbus_ok;    // requesting, in range
  logic i_win, d_win;         // ROM winner this cycle
  logic force_i;
  owner_e owner_q;

  assign ibus_addr_ext = ADDR_MAX'(ibus_addr);
  assign dbus_addr_ext = ADDR_MAX'(dbus_addr);

  assign ibus_flt = ibus_req &&  is_rom_fault(ibus_addr_ext, WIDTH, ROM_ADDR_WIDTH);
  assign ibus_ok  = ibus_req && !is_rom_fault(ibus_addr_ext, WIDTH, ROM_ADDR_WIDTH);
  assign dbus_flt = dbus_req &&  is_rom_fault(dbus_addr_ext, WIDTH, ROM_ADDR_WIDTH);
  assign dbus_ok  = dbus_req && !is_rom_fault(dbus_addr_ext, WIDTH, ROM_ADDR_WIDTH);

  // dbus wins by default; ibus takes the ROM when dbus is not competing or
  // when it has been starved long enough. Reset masks every winner.
  assign i_win = !rst && ibus_ok && (!dbus_ok || force_i);
  assign d_win = !rst && dbus_ok && !i_win;

  // Faulting requests bypass the ROM, so they are granted unconditionally.
  assign ibus_gnt = !rst && (ibus_flt || i_win);
  assign dbus_gnt = !rst && (dbus_flt || d_win);

  assign rom_rd_en = i_win || d_win;

  always_comb begin
    rom_addr = '0;
    if (i_win)      rom_addr = ibus_addr[ROM_ADDR_WIDTH+1:2];
    else if (d_win) rom_addr = dbus_addr[ROM_ADDR_WIDTH+1:2];
  end

  rom_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk          (clk),
    .rst          (rst),
    .ibus_req     (ibus_req),
    .ibus_inrange (ibus_ok),
    .ibus_gnt     (ibus_gnt),
    .force_i      (force_i)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      ibus_rvalid <= 1'b0;
      ibus_fault  <= 1'b0;
      dbus_rvalid <= 1'b0;
      dbus_fault  <= 1'b0;
    end else begin
      owner_q     <= i_win ? OWN_IBUS : (d_win ? OWN_DBUS : OWN_NONE);
      ibus_rvalid <= ibus_gnt;
      ibus_fault  <= ibus_gnt && ibus_flt;
      dbus_rvalid <= dbus_gnt;
      dbus_fault  <= dbus_gnt && dbus_flt;
    end
  end

  // ROM data is steered only to the port that owned last cycle's read; a
  // faulting or idle port, and the first cycle after reset, see zero.
  assign ibus_rdata = (owner_q == OWN_IBUS) ? rom_rd_data : '0;
  assign dbus_rdata = (owner_q == OWN_DBUS) ? rom_rd_data : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter (limit 4 and limit 0 builds).
module tb_rom_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // ROM contents: word 4 holds 0xDEADBEEF, every other word i holds 0xA5A50000+i.
  function automatic logic [31:0] rom_word(input logic [9:0] a);
    if (a == 10'd4) return 32'hDEAD_BEEF;
    return 32'hA5A5_0000 + 32'(a);
  endfunction

  // ---- DUT with STARVE_LIMIT=4 ----
  logic        ibus_req = 1'b0, dbus_req = 1'b0;
  logic [31:0] ibus_addr = '0, dbus_addr = '0;
  logic        ibus_gnt, ibus_rvalid, ibus_fault, dbus_gnt, dbus_rvalid, dbus_fault;
  logic [31:0] ibus_rdata, dbus_rdata, rom_rd_data;
  logic        rom_rd_en;
  logic [9:0]  rom_addr;

  rom_arbiter #(.WIDTH(32), .ROM_ADDR_WIDTH(10), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .ibus_fault(ibus_fault),
    .dbus_req(dbus_req), .dbus_addr(dbus_addr), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .dbus_fault(dbus_fault),
    .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rd_data(rom_rd_data)
  );

  always @(posedge clk) if (rom_rd_en) rom_rd_data <= rom_word(rom_addr);

  // ---- DUT with STARVE_LIMIT=0 (guard disabled) ----
  logic        z_ibus_req = 1'b0, z_dbus_req = 1'b0;
  logic [31:0] z_ibus_addr = '0, z_dbus_addr = '0;
  logic        z_ibus_gnt, z_ibus_rvalid, z_ibus_fault, z_dbus_gnt, z_dbus_rvalid, z_dbus_fault;
  logic [31:0] z_ibus_rdata, z_dbus_rdata, z_rom_rd_data;
  logic        z_rom_rd_en;
  logic [9:0]  z_rom_addr;

  rom_arbiter #(.WIDTH(32), .ROM_ADDR_WIDTH(10), .STARVE_LIMIT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .ibus_req(z_ibus_req), .ibus_addr(z_ibus_addr), .ibus_gnt(z_ibus_gnt),
    .ibus_rvalid(z_ibus_rvalid), .ibus_rdata(z_ibus_rdata), .ibus_fault(z_ibus_fault),
    .dbus_req(z_dbus_req), .dbus_addr(z_dbus_addr), .dbus_gnt(z_dbus_gnt),
    .dbus_rvalid(z_dbus_rvalid), .dbus_rdata(z_dbus_rdata), .dbus_fault(z_dbus_fault),
    .rom_rd_en(z_rom_rd_en), .rom_addr(z_rom_addr), .rom_rd_data(z_rom_rd_data)
  );

  always @(posedge clk) if (z_rom_rd_en) z_rom_rd_data <= rom_word(z_rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with a request pending to show gnt is masked.
    ibus_req = 1'b1; ibus_addr = 32'h10;
    #12;
    chk("rst_ibus_gnt",  {31'b0, ibus_gnt},    32'd0);
    chk("rst_rd_en",     {31'b0, rom_rd_en},   32'd0);
    chk("rst_rom_addr",  32'(rom_addr),        32'd0);
    chk("rst_ibus_rvld", {31'b0, ibus_rvalid}, 32'd0);
    chk("rst_dbus_rvld", {31'b0, dbus_rvalid}, 32'd0);
    chk("rst_ibus_rdat", ibus_rdata,           32'd0);
    ibus_req = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();

    // 1: single ibus read of word 4.
    ibus_req = 1'b1; ibus_addr = 32'h0000_0010;
    #1;
    chk("t1_ibus_gnt",  {31'b0, ibus_gnt},  32'd1);
    chk("t1_rd_en",     {31'b0, rom_rd_en}, 32'd1);
    chk("t1_rom_addr",  32'(rom_addr),      32'd4);
    chk("t1_dbus_gnt",  {31'b0, dbus_gnt},  32'd0);
    cyc();
    ibus_req = 1'b0;
    chk("t1_ibus_rvld", {31'b0, ibus_rvalid}, 32'd1);
    chk("t1_ibus_rdat", ibus_rdata,           32'hDEAD_BEEF);
    chk("t1_ibus_flt",  {31'b0, ibus_fault},  32'd0);
    chk("t1_dbus_rvld", {31'b0, dbus_rvalid}, 32'd0);
    chk("t1_dbus_rdat", dbus_rdata,           32'd0);
    cyc();
    chk("t1_idle_rvld", {31'b0, ibus_rvalid}, 32'd0);
    chk("t1_idle_rden", {31'b0, rom_rd_en},   32'd0);

    // 2: both in range, dbus wins.
    ibus_req = 1'b1; ibus_addr = 32'h0;
    dbus_req = 1'b1; dbus_addr = 32'h8;
    #1;
    chk("t2_dbus_gnt",  {31'b0, dbus_gnt}, 32'd1);
    chk("t2_ibus_gnt",  {31'b0, ibus_gnt}, 32'd0);
    chk("t2_rom_addr",  32'(rom_addr),     32'd2);
    cyc();
    ibus_req = 1'b0; dbus_req = 1'b0;
    chk("t2_dbus_rvld", {31'b0, dbus_rvalid}, 32'd1);
    chk("t2_dbus_rdat", dbus_rdata,           32'hA5A5_0002);
    chk("t2_ibus_rvld", {31'b0, ibus_rvalid}, 32'd0);
    chk("t2_ibus_rdat", ibus_rdata,           32'd0);
    cyc();

    // 3: starvation guard; ibus forced on cycles 4 and 9 (counter restarts).
    ibus_req = 1'b1; ibus_addr = 32'h0;
    dbus_req = 1'b1; dbus_addr = 32'h8;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t3_ibus_gnt_%0d", i), {31'b0, ibus_gnt}, {31'b0, (i == 4 || i == 9)});
      chk($sformatf("t3_dbus_gnt_%0d", i), {31'b0, dbus_gnt}, {31'b0, !(i == 4 || i == 9)});
      cyc();
      chk($sformatf("t3_ibus_rdat_%0d", i), ibus_rdata,
          (i == 4 || i == 9) ? 32'hA5A5_0000 : 32'd0);
    end
    ibus_req = 1'b0; dbus_req = 1'b0;
    cyc();

    // 4: ibus faults, dbus in range -> both granted.
    ibus_req = 1'b1; ibus_addr = 32'h0000_1000;
    dbus_req = 1'b1; dbus_addr = 32'h0000_0004;
    #1;
    chk("t4_ibus_gnt",  {31'b0, ibus_gnt}, 32'd1);
    chk("t4_dbus_gnt",  {31'b0, dbus_gnt}, 32'd1);
    chk("t4_rom_addr",  32'(rom_addr),     32'd1);
    cyc();
    ibus_req = 1'b0; dbus_req = 1'b0;
    chk("t4_ibus_rvld", {31'b0, ibus_rvalid}, 32'd1);
    chk("t4_ibus_flt",  {31'b0, ibus_fault},  32'd1);
    chk("t4_ibus_rdat", ibus_rdata,           32'd0);
    chk("t4_dbus_rvld", {31'b0, dbus_rvalid}, 32'd1);
    chk("t4_dbus_flt",  {31'b0, dbus_fault},  32'd0);
    chk("t4_dbus_rdat", dbus_rdata,           32'hA5A5_0001);
    cyc();

    // Boundaries: last ROM word is in range; top address faults alone.
    ibus_req = 1'b1; ibus_addr = 32'h0000_0FFC;
    dbus_req = 1'b1; dbus_addr = 32'hFFFF_FFFC;
    #1;
    chk("b_ibus_gnt",  {31'b0, ibus_gnt},  32'd1);
    chk("b_dbus_gnt",  {31'b0, dbus_gnt},  32'd1);
    chk("b_rom_addr",  32'(rom_addr),      32'h3FF);
    cyc();
    ibus_req = 1'b0;
    chk("b_ibus_rdat", ibus_rdata,           32'hA5A5_03FF);
    chk("b_dbus_flt",  {31'b0, dbus_fault},  32'd1);
    chk("b_dbus_rdat", dbus_rdata,           32'd0);
    #1;
    chk("b_dflt_rden", {31'b0, rom_rd_en},   32'd0);
    chk("b_dflt_radr", 32'(rom_addr),        32'd0);
    cyc();
    dbus_req = 1'b0;
    cyc();

    // 5: reset straight after an ibus grant drops the response.
    ibus_req = 1'b1; ibus_addr = 32'h0000_0010;
    #1;
    chk("t5_ibus_gnt",  {31'b0, ibus_gnt}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_gnt_in_rst", {31'b0, ibus_gnt},  32'd0);
    chk("t5_rden_in_rst", {31'b0, rom_rd_en}, 32'd0);
    cyc();
    ibus_req = 1'b0;
    chk("t5_ibus_rvld", {31'b0, ibus_rvalid}, 32'd0);
    chk("t5_ibus_rdat", ibus_rdata,           32'd0);
    rst = 1'b0;
    cyc();
    chk("t5_post_rvld", {31'b0, ibus_rvalid}, 32'd0);
    chk("t5_post_rdat", ibus_rdata,           32'd0);
    ibus_req = 1'b1; ibus_addr = 32'h0000_000C;
    #1;
    chk("t5_new_gnt",   {31'b0, ibus_gnt},    32'd1);
    cyc();
    ibus_req = 1'b0;
    chk("t5_new_rvld",  {31'b0, ibus_rvalid}, 32'd1);
    chk("t5_new_rdat",  ibus_rdata,           32'hA5A5_0003);
    cyc();

    // 6: guard disabled -> dbus wins every cycle.
    z_ibus_req = 1'b1; z_ibus_addr = 32'h0;
    z_dbus_req = 1'b1; z_dbus_addr = 32'h8;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("t6_ibus_gnt_%0d", i), {31'b0, z_ibus_gnt}, 32'd0);
      chk($sformatf("t6_dbus_gnt_%0d", i), {31'b0, z_dbus_gnt}, 32'd1);
      cyc();
    end
    z_ibus_req = 1'b0; z_dbus_req = 1'b0;
    chk("t6_dbus_rdat", z_dbus_rdata, 32'hA5A5_0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
